muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Iterative multiply/divide execution unit downstream of the register file.
- Consumes the AR/BR read ports as operands.
- Produces a result for the register-file write-data path.
- Controller holds register write-back until done.
- One shift-add or restoring-subtract step per clock; start/busy/done handshake.

Parameters:
- WIDTH, 16, operand/result width in bits (equals register width).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (unit resets while reset==0).
- start  input  1  request; accepted only in IDLE.
- op  input  2  00 MUL low half, 01 MUL high half, 10 DIV quotient, 11 DIV remainder.
- AR  input  WIDTH  operand A (multiplicand/dividend), from register file AR.
- BR  input  WIDTH  operand B (multiplier/divisor), from register file BR.
- result  output  WIDTH  selected result, held until next accepted start.
- busy  output  1  high from the cycle after acceptance until done.
- done  output  1  one-cycle pulse: result valid.
- div_zero  output  1  sticky with result: last DIV/REM had BR==0.

Behaviour:
- Reset (async, reset==0): state=IDLE, result=0, busy=0, done=0, div_zero=0, counter=0, all datapath registers 0.
- FSM states: IDLE, RUN, FIN.
- IDLE: start=1 captures AR, BR and op, clears div_zero, sets busy=1, loads counter=WIDTH and goes to RUN.
- IDLE, DIV/REM with BR==0: skip RUN and go straight to FIN with div_zero=1.
- RUN, MUL: 2*WIDTH-bit product register, LSB-first shift-add.
- RUN, DIV: restoring division on a WIDTH+1-bit partial remainder, quotient bits shifted in LSB.
- RUN: counter decrements each cycle; at counter==1 go to FIN.
- FIN: result takes the op-selected half/quotient/remainder. done=1 for exactly this cycle; busy=0 from this cycle. Return to IDLE.
- Latency: start accepted at edge N gives done at edge N+WIDTH+1 (17 cycles for WIDTH=16).
- Divide by zero: done at edge N+1. Quotient = all ones, remainder = AR, div_zero=1.
- start while busy (RUN or FIN) is ignored, not queued. Operands are sampled only at acceptance, so AR/BR may change during RUN.
- start held high continuously: a new operation is accepted in the IDLE cycle after FIN, so back-to-back throughput is WIDTH+2 cycles.
- Reset asserted mid-operation aborts immediately; no done pulse is produced.
- All arithmetic is unsigned modulo 2^WIDTH unless the optional feature is enabled.

Optional Feature:
Macro MULDIV_SIGNED_EN.
- Defined: operands are two's complement.
  - Magnitudes are taken at capture; the result is negated in FIN when required.
  - Product sign = sA^sB.
  - Quotient sign = sA^sB; remainder sign = sA (truncating division).
  - Overflow case 0x8000 / 0xFFFF gives quotient 0x8000, remainder 0x0000, div_zero=0.
  - Divide by zero is unchanged (quotient all ones, remainder AR).
  - Latency is identical.
- Undefined: unsigned only; no sign logic is synthesized.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings OP_MUL_LO, OP_MUL_HI, OP_DIV_Q, OP_DIV_R;
  - FSM state enum (IDLE/RUN/FIN);
  - WIDTH default 16.
- One natural sub-module, muldiv_step: combinational single-iteration datapath (add-or-pass for MUL, trial-subtract for DIV). The top block holds the FSM, counter and registers.

Test Plan:
- MUL low, AR=0x0123, BR=0x0010, start one cycle -> busy next cycle, done at edge +17, result=0x1230, div_zero=0.
- MUL high, AR=0xFFFF, BR=0xFFFF -> result=0xFFFE; repeat with op=00 -> result=0x0001.
- DIV, AR=100, BR=7 -> result=0x000E; op=11 -> result=0x0002.
- Divide by zero, AR=0x1234, BR=0:
  - op=10 -> done at edge +1, result=0xFFFF, div_zero=1;
  - op=11 -> result=0x1234.
- Robustness: pulse start again mid-RUN -> ignored, single done. Assert reset at RUN cycle 8 -> busy=0, result=0 asynchronously, no done.
- With MULDIV_SIGNED_EN, AR=0xFFF9 (-7), BR=0x0002:
  - op=10 -> 0xFFFD;
  - op=11 -> 0xFFFF;
  - op=00 -> 0xFFF2.

Source files
------------

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings, FSM states and default width for muldiv_unit
package muldiv_pkg;

   localparam int MULDIV_WIDTH = 16;

   localparam logic [1:0] OP_MUL_LO = 2'b00;
   localparam logic [1:0] OP_MUL_HI = 2'b01;
   localparam logic [1:0] OP_DIV_Q  = 2'b10;
   localparam logic [1:0] OP_DIV_R  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational iteration: shift-add multiply or restoring-divide step
module muldiv_step #(
   parameter int WIDTH = 16
) (
   input  logic             div_mode,
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] opnd,
   output logic [WIDTH-1:0] acc_next,
   output logic [WIDTH-1:0] lo_next
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] shifted;
   logic           ge;

   // Partial remainder stays below the divisor, so WIDTH bits of acc suffice.
   always_comb begin
      sum     = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
      shifted = {acc, lo[WIDTH-1]};
      ge      = shifted >= {1'b0, opnd};
      if (div_mode) begin
         acc_next = ge ? (shifted[WIDTH-1:0] - opnd) : shifted[WIDTH-1:0];
         lo_next  = {lo[WIDTH-2:0], ge};
      end else begin
         acc_next = sum[WIDTH:1];
         lo_next  = {sum[0], lo[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit; MULDIV_SIGNED_EN adds two's complement operands
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MULDIV_WIDTH,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] AR,
   input  logic [WIDTH-1:0] BR,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   state_t             state, state_next;
   logic [CNT_W-1:0]   cnt;
   logic [1:0]         op_q;
   logic [WIDTH-1:0]   opnd, acc, lo;
   logic [WIDTH-1:0]   acc_next, lo_next;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic               div0_q;
   logic               accept, step_en, fin_en, br_zero;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo, rem, fin_result;

   assign br_zero = (BR == '0);

`ifdef MULDIV_SIGNED_EN
   logic neg_q, neg_r;

   assign a_mag = AR[WIDTH-1] ? (~AR) + WIDTH'(1) : AR;
   assign b_mag = BR[WIDTH-1] ? (~BR) + WIDTH'(1) : BR;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (accept) begin
         neg_q <= AR[WIDTH-1] ^ BR[WIDTH-1];
         neg_r <= AR[WIDTH-1];
      end
   end
`else
   assign a_mag = AR;
   assign b_mag = BR;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) state_next = (op[1] && br_zero) ? FIN : RUN;
         RUN:  if (cnt == CNT_W'(1)) state_next = FIN;
         FIN:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      accept  = (state == IDLE) && start;
      step_en = (state == RUN);
      fin_en  = (state == FIN);
   end

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .div_mode (op_q[1]),
      .acc      (acc),
      .lo       (lo),
      .opnd     (opnd),
      .acc_next (acc_next),
      .lo_next  (lo_next)
   );

   // Sign fix-up happens on magnitudes; a zero divisor returns the raw dividend held in lo.
   always_comb begin
      prod = {acc, lo};
      quo  = lo;
      rem  = acc;
`ifdef MULDIV_SIGNED_EN
      if (neg_q) begin
         prod = ~prod + (2*WIDTH)'(1);
         quo  = ~quo + WIDTH'(1);
      end
      if (neg_r) rem = ~rem + WIDTH'(1);
`endif
      case (op_q)
         OP_MUL_LO: fin_result = prod[WIDTH-1:0];
         OP_MUL_HI: fin_result = prod[2*WIDTH-1:WIDTH];
         OP_DIV_Q:  fin_result = div0_q ? '1 : quo;
         default:   fin_result = div0_q ? lo : rem;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt      <= '0;
         op_q     <= '0;
         opnd     <= '0;
         acc      <= '0;
         lo       <= '0;
         div0_q   <= 1'b0;
         result   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            op_q     <= op;
            cnt      <= CNT_W'(WIDTH);
            busy     <= 1'b1;
            div_zero <= 1'b0;
            div0_q   <= op[1] && br_zero;
            acc      <= '0;
            if (op[1]) begin
               opnd <= b_mag;
               lo   <= br_zero ? AR : a_mag;
            end else begin
               opnd <= a_mag;
               lo   <= b_mag;
            end
         end else if (step_en) begin
            acc <= acc_next;
            lo  <= lo_next;
            cnt <= cnt - CNT_W'(1);
         end else if (fin_en) begin
            result   <= fin_result;
            done     <= 1'b1;
            busy     <= 1'b0;
            div_zero <= div0_q;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed vector bench for muldiv_unit
module tb_muldiv_unit;
   import muldiv_pkg::*;

`ifdef MULDIV_SIGNED_EN
   localparam bit SGN = 1'b1;
`else
   localparam bit SGN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [15:0] AR = '0;
   logic [15:0] BR = '0;
   logic [15:0] result;
   logic        busy, done, div_zero;

   int checks = 0;
   int failures = 0;

   muldiv_unit dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .AR       (AR),
      .BR       (BR),
      .result   (result),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [1:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic        dz;
      int          lat;
   } vec_t;

   vec_t vecs[15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                        output int lat);
      @(negedge clock);
      op = o; AR = a; BR = b; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      check("busy_after_accept", {31'b0, busy}, 32'd1);
      AR = 16'hDEAD; BR = 16'hBEEF;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clock); #1;
         if (done) begin
            lat = k;
            break;
         end
      end
   endtask

   initial begin
      int lat;
      int ndone;
      int d0, d1;

      vecs[0]  = '{OP_MUL_LO, 16'h0123, 16'h0010, 16'h1230, 1'b0, 17};
      vecs[1]  = '{OP_MUL_HI, 16'hFFFF, 16'hFFFF, SGN ? 16'h0000 : 16'hFFFE, 1'b0, 17};
      vecs[2]  = '{OP_MUL_LO, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 17};
      vecs[3]  = '{OP_DIV_Q,  16'd100,  16'd7,    16'h000E, 1'b0, 17};
      vecs[4]  = '{OP_DIV_R,  16'd100,  16'd7,    16'h0002, 1'b0, 17};
      vecs[5]  = '{OP_DIV_Q,  16'h1234, 16'h0000, 16'hFFFF, 1'b1, 1};
      vecs[6]  = '{OP_DIV_R,  16'h1234, 16'h0000, 16'h1234, 1'b1, 1};
      vecs[7]  = '{OP_DIV_Q,  16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 17};
      vecs[8]  = '{OP_DIV_R,  16'h0005, 16'h0009, 16'h0005, 1'b0, 17};
      vecs[9]  = '{OP_MUL_HI, 16'hFFF9, 16'h0002, SGN ? 16'hFFFF : 16'h0001, 1'b0, 17};
      vecs[10] = '{OP_DIV_Q,  16'hFFF9, 16'h0002, SGN ? 16'hFFFD : 16'h7FFC, 1'b0, 17};
      vecs[11] = '{OP_DIV_R,  16'hFFF9, 16'h0002, SGN ? 16'hFFFF : 16'h0001, 1'b0, 17};
      vecs[12] = '{OP_MUL_LO, 16'hFFF9, 16'h0002, 16'hFFF2, 1'b0, 17};
      vecs[13] = '{OP_DIV_Q,  16'h8000, 16'hFFFF, SGN ? 16'h8000 : 16'h0000, 1'b0, 17};
      vecs[14] = '{OP_DIV_R,  16'h8000, 16'hFFFF, SGN ? 16'h0000 : 16'h8000, 1'b0, 17};

      repeat (2) @(posedge clock);
      #1;
      check("reset_result", {16'b0, result}, 32'h0);
      check("reset_busy", {31'b0, busy}, 32'h0);
      check("reset_done", {31'b0, done}, 32'h0);
      check("reset_div_zero", {31'b0, div_zero}, 32'h0);
      @(negedge clock);
      reset = 1'b1;

      for (int i = 0; i < 15; i++) begin
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
         check($sformatf("latency[%0d]", i), lat, vecs[i].lat);
         check($sformatf("result[%0d]", i), {16'b0, result}, {16'b0, vecs[i].res});
         check($sformatf("div_zero[%0d]", i), {31'b0, div_zero}, {31'b0, vecs[i].dz});
         check($sformatf("busy_at_done[%0d]", i), {31'b0, busy}, 32'h0);
         @(posedge clock); #1;
         check($sformatf("done_single[%0d]", i), {31'b0, done}, 32'h0);
      end

      // Start pulsed mid-RUN must be ignored.
      @(negedge clock);
      op = OP_MUL_LO; AR = 16'd3; BR = 16'd5; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      ndone = 0; d0 = -1;
      for (int k = 1; k <= 45; k++) begin
         if (k == 5) begin
            op = OP_DIV_Q; AR = 16'd9; BR = 16'd3; start = 1'b1;
         end
         if (k == 6) start = 1'b0;
         @(posedge clock); #1;
         if (done) begin
            ndone++;
            if (d0 < 0) d0 = k;
         end
      end
      check("midrun_done_count", ndone, 1);
      check("midrun_latency", d0, 17);
      check("midrun_result", {16'b0, result}, 32'd15);

      // Start held high: back-to-back operations every WIDTH+2 cycles.
      @(negedge clock);
      op = OP_MUL_LO; AR = 16'd4; BR = 16'd6; start = 1'b1;
      d0 = -1; d1 = -1;
      for (int k = 0; k <= 60; k++) begin
         @(posedge clock); #1;
         if (done) begin
            if (d0 < 0) d0 = k;
            else begin
               d1 = k;
               break;
            end
         end
      end
      start = 1'b0;
      check("b2b_first_done", d0, 17);
      check("b2b_second_done", d1, 35);
      check("b2b_result", {16'b0, result}, 32'd24);

      // Reset during RUN aborts asynchronously with no done.
      @(negedge clock);
      op = OP_MUL_LO; AR = 16'h0123; BR = 16'h0010; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (7) @(posedge clock);
      #2;
      reset = 1'b0;
      #1;
      check("abort_busy", {31'b0, busy}, 32'h0);
      check("abort_result", {16'b0, result}, 32'h0);
      check("abort_done", {31'b0, done}, 32'h0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      ndone = 0;
      for (int k = 0; k < 25; k++) begin
         @(posedge clock); #1;
         if (done || busy) ndone++;
      end
      check("abort_no_done", ndone, 0);

      do_op(OP_MUL_LO, 16'h0123, 16'h0010, lat);
      check("post_abort_latency", lat, 17);
      check("post_abort_result", {16'b0, result}, 32'h1230);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
